pwl_act_pipe: RTL

//  Parametrised, 3-stage pipelined piecewise-linear activation unit: 7-segment PWL sigmoid,

---
 rtl/pwl_act_if.sv | 23 ++
 rtl/pwl_act_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pwl_act_if.sv
// Valid/ready stream bundle for the PWL activation unit: sample in (x, mode), result out (y).
// master = upstream producer / downstream consumer side, slave = the activation unit.
interface pwl_act_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic          mode_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] y_out;

  modport master (
    output in_valid, x_in, mode_in, out_ready,
    input  in_ready, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, mode_in, out_ready,
    output in_ready, out_valid, y_out
  );
endinterface

// File: rtl/pwl_act_pipe.sv
// 3-stage pipelined 7-segment PWL sigmoid / tanh (tanh = 2*sigmoid(2x) - 1) with valid/ready flow.
// Define PWL_ROUND_EN to round the slope product half-up instead of truncating it.
module pwl_act_pipe #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  pwl_act_if.slave  bus
);

  localparam int PW = DW + 10;

  typedef enum logic [2:0] {SEG0, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6} seg_e;

  // Breakpoints in the DW+1 bit operand domain
  localparam logic signed [DW:0] P1 = (DW+1)'(1) << FRAC;
  localparam logic signed [DW:0] P2 = P1 <<< 1;
  localparam logic signed [DW:0] P4 = P1 <<< 2;
  localparam logic signed [DW:0] N1 = -P1;
  localparam logic signed [DW:0] N2 = -P2;
  localparam logic signed [DW:0] N4 = -P4;

  localparam logic signed [PW-1:0] ONE_W  = PW'(1) << FRAC;
  localparam logic signed [PW-1:0] HALF_W = PW'(128);

  logic                 s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [DW:0]   xs_q, xs_d;
  seg_e                 seg1_q, seg1_d, seg2_q;
  logic                 mode1_q, mode2_q;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [DW-1:0]        y_q, y_d;
  logic                 en;

  logic [7:0]           slope;
  logic signed [PW-1:0] t, icpt, sig, sig_c;

  assign en            = !s3_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = s3_valid_q;
  assign bus.y_out     = y_q;

  // S1: doubling for tanh is done one bit wider so it never overflows
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    xs_d   = bus.mode_in ? {bus.x_in, 1'b0} : {bus.x_in[DW-1], bus.x_in};
    seg1_d = SEG6;
    if      (xs_d < N4) seg1_d = SEG0;
    else if (xs_d < N2) seg1_d = SEG1;
    else if (xs_d < N1) seg1_d = SEG2;
    else if (xs_d < P1) seg1_d = SEG3;
    else if (xs_d < P2) seg1_d = SEG4;
    else if (xs_d < P4) seg1_d = SEG5;
  end

  // S2: Q0.8 slope, zero in the saturated segments (their result is forced later)
  always_comb begin
    slope = 8'd0;
    case (seg1_q)
      SEG1, SEG5: slope = 8'd13;
      SEG2, SEG4: slope = 8'd39;
      SEG3:       slope = 8'd59;
      default:    slope = 8'd0;
    endcase
    prod_d = PW'(xs_q) * PW'($signed({1'b0, slope}));
  end

  // S3: drop the Q0.8 slope fraction, add intercept, saturate, then reshape for tanh
  always_comb begin
`ifdef PWL_ROUND_EN
    t = (prod_q + HALF_W) >>> 8;
`else
    t = prod_q >>> 8;
`endif
    icpt = '0;
    case (seg2_q)
      SEG1:    icpt = PW'(57)  << (FRAC - 8);
      SEG2:    icpt = PW'(108) << (FRAC - 8);
      SEG3:    icpt = PW'(128) << (FRAC - 8);
      SEG4:    icpt = PW'(148) << (FRAC - 8);
      SEG5:    icpt = PW'(199) << (FRAC - 8);
      default: icpt = '0;
    endcase
    sig = t + icpt;
    if      (seg2_q == SEG0) sig_c = '0;
    else if (seg2_q == SEG6) sig_c = ONE_W;
    else if (sig[PW-1])      sig_c = '0;
    else if (sig > ONE_W)    sig_c = ONE_W;
    else                     sig_c = sig;
    y_d = mode2_q ? DW'((sig_c <<< 1) - ONE_W) : DW'(sig_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      xs_q       <= '0;
      seg1_q     <= SEG0;
      mode1_q    <= 1'b0;
      prod_q     <= '0;
      seg2_q     <= SEG0;
      mode2_q    <= 1'b0;
      y_q        <= '0;
    end else if (en) begin
      // NOTE: non-blocking so every stage samples the previous stage's old value on the same edge.
      s1_valid_q <= bus.in_valid;
      xs_q       <= xs_d;
      seg1_q     <= seg1_d;
      mode1_q    <= bus.mode_in;
      s2_valid_q <= s1_valid_q;
      prod_q     <= prod_d;
      seg2_q     <= seg1_q;
      mode2_q    <= mode1_q;
      s3_valid_q <= s2_valid_q;
      y_q        <= y_d;
    end
  end

endmodule
